// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for param_fifo and its testbenches.
package param_fifo_pkg;

  localparam logic RST_VALID = 1'b0;
  localparam logic RST_ERR   = 1'b0;

  // Count must be able to hold DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointer increment that wraps at any depth, not only powers of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// Simple dual-port storage array: synchronous write, registered read, no reset.
module param_fifo_ram import param_fifo_pkg::*; #(
  parameter int unsigned DEPTH      = 220,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ptr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [ptr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-before-write: a same-cycle write to rd_addr is not seen until later.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count and threshold flags.
// Sticky Overflow/Underflow are built only when PARAM_FIFO_ERR_FLAGS_EN is defined.
module param_fifo import param_fifo_pkg::*; #(
  parameter int unsigned DEPTH      = 220,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 4,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         Request,
  input  logic                         Write_Req,
  input  logic                         Data_Valid_In,
  input  logic [DATA_WIDTH-1:0]        Data_In,
  input  logic                         Read_Req,
  output logic [DATA_WIDTH-1:0]        Data_Out,
  output logic                         Data_Valid_Out,
  output logic                         Empty,
  output logic                         Full,
  output logic                         Almost_Empty,
  output logic                         Almost_Full,
  output logic [cnt_width(DEPTH)-1:0]  Count,
  output logic                         Overflow,
  output logic                         Underflow
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  valid_q;
  logic                  dout_zero_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wa, ra, rd_acc, wr_acc;

  assign Empty        = (count_q == '0);
  assign Full         = (count_q == CNT_W'(DEPTH));
  assign Almost_Empty = (32'(count_q) <= AE_THRESH);
  assign Almost_Full  = (32'(count_q) >= AF_THRESH);
  assign Count        = count_q;

  assign wa     = Request & Write_Req & Data_Valid_In;
  assign ra     = Request & Read_Req;
  assign rd_acc = ra & ~Empty;
  assign wr_acc = wa & (~Full | rd_acc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= RST_VALID;
      dout_zero_q <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr_q <= PTR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
      if (rd_acc) rd_ptr_q <= PTR_W'(next_ptr(32'(rd_ptr_q), DEPTH));
      if (wr_acc && !rd_acc)      count_q <= count_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CNT_W'(1);
      valid_q <= rd_acc;
      if (!Request)    dout_zero_q <= 1'b1;
      else if (rd_acc) dout_zero_q <= 1'b0;
    end
  end

  // The RAM read register holds its word; this mask provides the zeroed output.
  assign Data_Out       = dout_zero_q ? '0 : ram_rdata;
  assign Data_Valid_Out = valid_q;

  param_fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (Data_In),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= RST_ERR;
      unf_q <= RST_ERR;
    end else begin
      if (wa && !wr_acc) ovf_q <= 1'b1;
      if (ra && Empty)   unf_q <= 1'b1;
    end
  end

  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`else
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

endmodule
